// File: rtl/imm_ctrl_pkg.sv
// imm_ctrl_pkg
//   Shared definitions for the immediate-instruction issue controller:
//   controller state encoding, ALU func codes, flag bit positions and
//   fixed datapath widths.
package imm_ctrl_pkg;

    localparam int DATA_W  = 32;
    localparam int IMM_W   = 16;
    localparam int RADDR_W = 5;
    localparam int FUNC_W  = 2;
    localparam int FLAGS_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        FIRE    = 3'd2,
        CAPTURE = 3'd3,
        WB      = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam logic [FUNC_W-1:0] FUNC_ADDI = 2'd0;
    localparam logic [FUNC_W-1:0] FUNC_NEGI = 2'd1;

    // Bit positions inside flags_q = {carry, sign, ovf, zero}
    localparam int CARRY = 3;
    localparam int SIGN  = 2;
    localparam int OVF   = 1;
    localparam int ZERO  = 0;

    function automatic logic func_is_legal(input logic [FUNC_W-1:0] f);
        return (f == FUNC_ADDI) || (f == FUNC_NEGI);
    endfunction

endpackage

// File: rtl/imm_issue_ctrl_if.sv
// imm_issue_ctrl_if
//   Bundles the decoder handshake, register-file ports and immediate-ALU
//   ports of the issue controller.
//   master : the controller (drives ready, ALU operands/enable, write port,
//            flags, done, err)
//   slave  : the surroundings (decoder, register file, immediate ALU)
interface imm_issue_ctrl_if;
    import imm_ctrl_pkg::*;

    // decoder handshake
    logic                 instr_valid;
    logic                 instr_ready;
    logic [RADDR_W-1:0]   instr_rs;
    logic [RADDR_W-1:0]   instr_rd;
    logic [FUNC_W-1:0]    instr_func;
    logic [IMM_W-1:0]     instr_imm;
    // register-file read (combinational)
    logic [RADDR_W-1:0]   rf_raddr;
    logic [DATA_W-1:0]    rf_rdata;
    // immediate ALU
    logic [DATA_W-1:0]    alu_inp1;
    logic [IMM_W-1:0]     alu_inp2;
    logic [FUNC_W-1:0]    alu_func;
    logic                 alu_ena;
    logic [DATA_W-1:0]    alu_res;
    logic                 alu_carry;
    logic                 alu_sign;
    logic                 alu_ovf;
    logic                 alu_zero;
    // register-file write
    logic                 rf_we;
    logic [RADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    // status
    logic [FLAGS_W-1:0]   flags_q;
    logic                 done;
    logic                 err;

    modport master (
        input  instr_valid, instr_rs, instr_rd, instr_func, instr_imm,
        input  rf_rdata,
        input  alu_res, alu_carry, alu_sign, alu_ovf, alu_zero,
        output instr_ready, rf_raddr,
        output alu_inp1, alu_inp2, alu_func, alu_ena,
        output rf_we, rf_waddr, rf_wdata,
        output flags_q, done, err
    );

    modport slave (
        output instr_valid, instr_rs, instr_rd, instr_func, instr_imm,
        output rf_rdata,
        output alu_res, alu_carry, alu_sign, alu_ovf, alu_zero,
        input  instr_ready, rf_raddr,
        input  alu_inp1, alu_inp2, alu_func, alu_ena,
        input  rf_we, rf_waddr, rf_wdata,
        input  flags_q, done, err
    );

endinterface

// File: rtl/imm_ctrl_fsm.sv
// imm_ctrl_fsm
//   State register and strobe decode for the immediate issue controller.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     instr_valid    decoder has an instruction
//     instr_func     func of the offered instruction (legality check)
//     wb_suppress    block the register-file write of the current instruction
//     instr_ready    high only in IDLE
//     accept         instr_valid & instr_ready
//     capture        high in CAPTURE; datapath latches result/flags
//     alu_ena, rf_we, done, err   registered strobes
module imm_ctrl_fsm
    import imm_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [FUNC_W-1:0] instr_func,
    input  logic              wb_suppress,
    output logic              instr_ready,
    output logic              accept,
    output logic              capture,
    output logic              alu_ena,
    output logic              rf_we,
    output logic              done,
    output logic              err
);

    state_t state_q, state_d;
    logic   alu_ena_q, alu_ena_d;
    logic   rf_we_q, rf_we_d;
    logic   done_q, done_d;
    logic   err_q, err_d;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = func_is_legal(instr_func) ? SETUP : ERR;
                end
            end
            SETUP:   state_d = FIRE;
            FIRE:    state_d = CAPTURE;
            CAPTURE: state_d = WB;
            WB:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so that they come out of
        // flops and are aligned with the state they belong to.
        alu_ena_d = (state_d == FIRE);
        rf_we_d   = (state_d == WB) && !wb_suppress;
        done_d    = (state_d == WB);
        err_d     = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            alu_ena_q <= 1'b0;
            rf_we_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_ena_q <= alu_ena_d;
            rf_we_q   <= rf_we_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign capture     = (state_q == CAPTURE);
    assign alu_ena     = alu_ena_q;
    assign rf_we       = rf_we_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: rtl/imm_issue_ctrl.sv
// imm_issue_ctrl
//   Issues one decoded immediate instruction at a time to the immediate ALU:
//   reads the source register on accept, presents operands for a full cycle,
//   pulses alu_ena for one cycle, captures result and flags, then writes the
//   result back. Illegal func codes produce a one-cycle err pulse only.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    imm_issue_ctrl_if.master (decoder, register file, ALU, status)
//   Build option:
//     IMM_R0_PROTECT_EN  when defined, a legal instruction targeting r0 runs
//                        normally (flags, done) but never asserts rf_we.
module imm_issue_ctrl
    import imm_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    imm_issue_ctrl_if.master      bus
);

    logic                 instr_ready;
    logic                 accept;
    logic                 capture;
    logic                 alu_ena;
    logic                 rf_we;
    logic                 done;
    logic                 err;
    logic                 wb_suppress;

    logic [RADDR_W-1:0]   rd_q,    rd_d;
    logic [DATA_W-1:0]    op1_q,   op1_d;
    logic [IMM_W-1:0]     imm_q,   imm_d;
    logic [FUNC_W-1:0]    func_q,  func_d;
    logic [DATA_W-1:0]    res_q,   res_d;
    logic [FLAGS_W-1:0]   flags_q, flags_d;

    imm_ctrl_fsm u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (bus.instr_valid),
        .instr_func  (bus.instr_func),
        .wb_suppress (wb_suppress),
        .instr_ready (instr_ready),
        .accept      (accept),
        .capture     (capture),
        .alu_ena     (alu_ena),
        .rf_we       (rf_we),
        .done        (done),
        .err         (err)
    );

`ifdef IMM_R0_PROTECT_EN
    assign wb_suppress = (rd_q == '0);
`else
    assign wb_suppress = 1'b0;
`endif

    always_comb begin
        rd_d    = rd_q;
        op1_d   = op1_q;
        imm_d   = imm_q;
        func_d  = func_q;
        res_d   = res_q;
        flags_d = flags_q;

        // Only legal instructions load the operand registers: the ALU-facing
        // outputs and rf_waddr then keep their previous values through an
        // ERR cycle instead of showing the illegal instruction's fields.
        if (accept && func_is_legal(bus.instr_func)) begin
            rd_d   = bus.instr_rd;
            op1_d  = bus.rf_rdata;
            imm_d  = bus.instr_imm;
            func_d = bus.instr_func;
        end

        if (capture) begin
            res_d          = bus.alu_res;
            flags_d[CARRY] = bus.alu_carry;
            flags_d[SIGN]  = bus.alu_sign;
            flags_d[OVF]   = bus.alu_ovf;
            flags_d[ZERO]  = bus.alu_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            op1_q   <= '0;
            imm_q   <= '0;
            func_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            rd_q    <= rd_d;
            op1_q   <= op1_d;
            imm_q   <= imm_d;
            func_q  <= func_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.rf_raddr    = bus.instr_rs;
    assign bus.alu_inp1    = op1_q;
    assign bus.alu_inp2    = imm_q;
    assign bus.alu_func    = func_q;
    assign bus.alu_ena     = alu_ena;
    assign bus.rf_we       = rf_we;
    assign bus.rf_waddr    = rd_q;
    assign bus.rf_wdata    = res_q;
    assign bus.flags_q     = flags_q;
    assign bus.done        = done;
    assign bus.err         = err;

endmodule

// File: doc/imm_issue_ctrl.md
# imm_issue_ctrl

Sequencing controller for immediate-format ALU instructions, on the issuing side of the immediate ALU unit's interface. It accepts one decoded immediate instruction through a valid/ready handshake and reads the source register. It then drives operands, the operation code and the edge-triggered enable into the immediate ALU, captures the result and flags, and writes the result back to the register file. It sits between the instruction decoder and the register file and immediate ALU in the multi-cycle datapath.

## Interface
- (no parameters; widths fixed: data 32, immediate 16, register address 5, func 2)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  decoder has an instruction
- instr_ready  out  1  controller can accept; high only in IDLE
- instr_rs / instr_rd  in  5  source / destination register
- instr_func  in  2  0 = add-immediate, 1 = negate-immediate, 2/3 = illegal
- instr_imm  in  16  raw immediate; the ALU sign-extends it
- rf_raddr  out  5  register-file read address; combinational read
- rf_rdata  in  32  read data, valid in the same cycle
- alu_inp1  out  32  operand to ALU
- alu_inp2  out  16  immediate to ALU
- alu_func  out  2  operation to ALU
- alu_ena  out  1  registered enable; ALU evaluates on its rising edge
- alu_res  in  32  ALU result
- alu_carry / alu_sign / alu_ovf / alu_zero  in  1 each  ALU flags
- rf_we  out  1  write-enable pulse
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- flags_q  out  4  last committed flags {carry, sign, ovf, zero}
- done  out  1  one-cycle pulse when a legal instruction completes
- err  out  1  one-cycle pulse on an illegal func

## Operation
- States: IDLE, SETUP, FIRE, CAPTURE, WB, ERR.
- IDLE: instr_ready=1 and rf_raddr=instr_rs.
  - On an accept (instr_valid & instr_ready), latch rd, func, imm and rf_rdata into op1_q.
  - Next state is ERR if func≥2, otherwise SETUP.
- SETUP: alu_inp1=op1_q, alu_inp2=imm_q, alu_func=func_q stable; alu_ena=0.
- FIRE: alu_ena=1 for exactly one cycle. Operands are unchanged.
- CAPTURE: alu_ena=0. At the end of the cycle, latch alu_res into res_q and the four flags into flags_q.
- WB: rf_we=1, rf_waddr=rd_q, rf_wdata=res_q, done=1. Next state is IDLE.
- ERR: err=1 for one cycle. No alu_ena, no rf_we, flags_q unchanged. Next state is IDLE.
- ALU operand outputs hold their last value outside SETUP to CAPTURE; they are never X after reset.
- The controller does not recompute the ALU arithmetic; results and flags pass through untouched.
- Reset values:
  - state=IDLE; instr_ready=1.
  - alu_ena, rf_we, done and err = 0.
  - alu_inp1, alu_inp2, alu_func, rf_waddr, rf_wdata and flags_q = 0.
- Reset mid-operation: all outputs go to their reset values immediately (alu_ena falls asynchronously). The in-flight instruction is discarded with no write-back.
- instr_valid held while busy: no accept. instr_ready rises on the cycle after WB or ERR.

## Timing
- Latency, legal instruction: the accept edge is edge 0. SETUP is cycle 1, FIRE cycle 2, CAPTURE cycle 3, WB cycle 4 (rf_we and done high). instr_ready is high again in cycle 5.
- Throughput: one legal instruction every 5 cycles; one illegal instruction every 2 cycles.
- flags_q changes at the end of CAPTURE, so it is visible from the WB cycle onward.
- Operands are stable one full cycle before the alu_ena rising edge and throughout the ena-high cycle.

## Configuration
- IMM_R0_PROTECT_EN defined: a legal instruction with rd=0 still fires the ALU, updates flags_q and pulses done, but rf_we stays 0.
- IMM_R0_PROTECT_EN undefined: rd=0 is written like any other register.

## Structure
- Shared package imm_ctrl_pkg holds:
  - the state enum;
  - the func constants FUNC_ADDI=2'd0 and FUNC_NEGI=2'd1;
  - the flag bit indices CARRY=3, SIGN=2, OVF=1, ZERO=0.
- One sub-module is natural: imm_ctrl_fsm, holding the state register and next-state/strobe decode. The datapath latches stay in the top.

## Test plan
- Add-immediate carry: r1=0x0000_0005, imm=0xFFFF, rd=3 → rf_wdata=0x0000_0004 to r3 in cycle 4; flags_q=4'b1000; done pulses once.
- Add-immediate overflow: r2=0x7FFF_FFFF, imm=0x0001 → 0x8000_0000; flags_q=4'b0110.
- Negate-immediate zero: imm=0x0000, rd=4 → rf_wdata=0; flags_q=4'b0001; alu_ena high for exactly cycle 2.
- Illegal func=2 → err in cycle 1; no alu_ena, no rf_we; flags_q unchanged; instr_ready high in cycle 2.
- Back-to-back with instr_valid held high → second accept exactly 5 cycles after the first; no overlap of rf_we and alu_ena.
- rst_n low during FIRE → alu_ena=0 immediately; no rf_we after release; instr_ready=1 in the first cycle after release. With IMM_R0_PROTECT_EN, rd=0 gives done=1 and rf_we=0.
